miss_msg_det_mc: RTL and testbench
==================================

// Module: miss_msg_det_mc
// PURPOSE
// Multi-channel MoldUDP64 missed-message detector; generalises single-stream miss detection to CH_N independent feeds.
// Sits after the MoldUDP64 header parser. Tracks the expected session ID and sequence number for each channel.
// Reports sequence gaps and session gaps per channel, flags stale/duplicate packets, and flags sequence arithmetic overflow.
// PARAMETERS
// CH_N        2          number of independent feeds tracked
// CH_W        $clog2(CH_N) (min 1)  channel index width
// SEQ_NUM_W   64         sequence number width
// SID_W       80         session ID width
// ML_W        16         message count width
// SEQ_START   1          first sequence number of a fresh session
// SID_GAP_MAX 1<<16      largest forward SID jump accepted; larger jumps are treated as stale
// PORTS
// clk                       in   1          clock
// reset                     in   1          synchronous, active-high reset
// v_i                       in   1          header valid, one per cycle max
// ch_i                      in   CH_W       channel of this header
// sid_i                     in   SID_W      session ID
// seq_num_i                 in   SEQ_NUM_W  sequence number of first message
// msg_cnt_i                 in   ML_W       message count (0 = heartbeat)
// eos_i                     in   1          end-of-session packet
// clr_i                     in   1          de-initialise channel clr_ch_i
// clr_ch_i                  in   CH_W       channel to clear
// miss_seq_num_v_o          out  1          sequence gap pulse
// miss_seq_num_ch_o         out  CH_W       channel of gap
// miss_seq_num_sid_o        out  SID_W      session of gap
// miss_seq_num_start_o      out  SEQ_NUM_W  first missing seq
// miss_seq_num_cnt_o        out  SEQ_NUM_W  missing message count
// miss_sid_v_o              out  1          session gap pulse
// miss_sid_ch_o             out  CH_W       channel of session gap
// miss_sid_start_o          out  SID_W      last tracked sid
// miss_sid_seq_num_start_o  out  SEQ_NUM_W  first missing seq in that sid
// miss_sid_cnt_o            out  SID_W      sid_i - tracked sid
// miss_sid_seq_num_end_o    out  SEQ_NUM_W  seq_num_i of new session (exclusive end)
// drop_v_o                  out  1          stale/duplicate header pulse
// err_v_o                   out  1          seq+cnt overflow pulse; channel de-initialised
// BEHAVIOUR
// - Per-channel state: init_q, eos_q, sid_q, seq_q (next expected seq). Reset: all cleared; every output 0.
// - All outputs are registered, 1-cycle latency from v_i. Pulses last exactly 1 cycle.
// - exp_end = seq_num_i + msg_cnt_i, computed SEQ_NUM_W+1 bits wide. If the carry is set: err_v_o=1, init_q<=0, no miss reported.
// - Uninitialised channel: adopt sid_i; seq_q<=exp_end; init_q<=1; no report.
// - sid_i==sid_q:
//     seq==seq_q  -> seq_q<=exp_end.
//     seq>seq_q   -> miss_seq_num (start=seq_q, cnt=seq_num_i-seq_q); seq_q<=exp_end.
//     seq<seq_q   -> overlap/duplicate; seq_q<=max(seq_q,exp_end); drop_v_o=1 only if exp_end<=seq_q.
//     Heartbeat (cnt 0) with seq>seq_q reports the gap.
// - 0 < sid_i-sid_q <= SID_GAP_MAX: adopt new sid; seq_q<=exp_end; eos_q<=eos_i.
//     No report if and only if sid_i==sid_q+1, eos_q==1 and seq_num_i==SEQ_START.
//     Otherwise miss_sid_v_o=1 with fields as above (start seq=seq_q).
// - sid_i<sid_q, or forward gap>SID_GAP_MAX: drop_v_o=1; state unchanged.
// - eos_i: sets eos_q after the sequence checks; an EOS packet at sid_q with seq>seq_q still reports miss_seq_num.
// - clr_i and v_i on the same channel in the same cycle: clr_i wins; the header is ignored with no output.
//   Different channels: both take effect.
// - Reset mid-stream: all channels de-initialised; the next header per channel re-initialises silently.
// - ch_i>=CH_N: drop_v_o=1, no state change.
// STRUCTURE
// - moldudp64_pkg: SEQ_NUM_W/SID_W/ML_W defaults, SEQ_START, and typedef ch_state_t {init, eos, sid, seq}.
// - Sub-module miss_msg_det_state: CH_N-entry ch_state_t register array with 1 read port (ch_i), 1 write port, and a clear port.
// - Top level holds a single shared compare/subtract datapath and the output registers.
// TESTING
// 1. Reset; ch0 sid=5 seq=1 cnt=3, then seq=4 cnt=2 -> no miss; seq_q[0]=6.
// 2. ch0 seq=10 cnt=1 -> miss_seq_num ch=0 sid=5 start=6 cnt=4; seq_q=11.
// 3. ch0 eos at seq=11; ch0 sid=6 seq=1 -> no miss_sid. ch1 sid=2 after sid=0 (no eos) seq=7 -> miss_sid start=0 cnt=2 end=7.
// 4. ch0 sid=4 -> drop_v_o. Duplicate seq=1 cnt=1 at seq_q=5 -> drop_v_o, seq_q unchanged.
// 5. Interleave ch0/ch1 back-to-back, random gaps -> per-channel reports match a scoreboard, channels independent.
// 6. seq=2^64-2 cnt=5 -> err_v_o, then next header re-inits silently. clr_i with v_i on same ch -> no output.

Source files
------------

// File: rtl/moldudp64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moldudp64_pkg
// Description : Shared widths, session constants and per-channel tracking
//               state type for the MoldUDP64 missed-message detectors.
// Revision    : 1.0 - initial release
// ============================================================================
package moldudp64_pkg;

    localparam int SEQ_NUM_W_DEF   = 64;
    localparam int SID_W_DEF       = 80;
    localparam int ML_W_DEF        = 16;
    localparam int SEQ_START_DEF   = 1;
    localparam int SID_GAP_MAX_DEF = 1 << 16;

    // Tracking state of one feed at the default widths.
    typedef struct packed {
        logic                     init;
        logic                     eos;
        logic [SID_W_DEF-1:0]     sid;
        logic [SEQ_NUM_W_DEF-1:0] seq;
    } ch_state_t;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miss_msg_det_state.sv
`default_nettype none
// ============================================================================
// Module      : miss_msg_det_state
// Description : CH_N-entry per-channel tracking state {init, eos, sid, seq}
//               with one read port, one write port and a clear port.
// Revision    : 1.0 - initial release
// ============================================================================
module miss_msg_det_state #(
    parameter int CH_N      = 2,
    parameter int CH_W      = 1,
    parameter int SID_W     = 80,
    parameter int SEQ_NUM_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH_W-1:0]      rd_ch_i,
    output logic                 rd_init_o,
    output logic                 rd_eos_o,
    output logic [SID_W-1:0]     rd_sid_o,
    output logic [SEQ_NUM_W-1:0] rd_seq_o,
    input  logic                 wr_en_i,
    input  logic [CH_W-1:0]      wr_ch_i,
    input  logic                 wr_init_i,
    input  logic                 wr_eos_i,
    input  logic [SID_W-1:0]     wr_sid_i,
    input  logic [SEQ_NUM_W-1:0] wr_seq_i,
    input  logic                 clr_i,
    input  logic [CH_W-1:0]      clr_ch_i
);

    typedef struct packed {
        logic                 init;
        logic                 eos;
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] seq;
    } st_t;

    st_t w_wr;
    st_t w_rd;
    st_t w_ent [CH_N];

    assign w_wr = '{init: wr_init_i, eos: wr_eos_i, sid: wr_sid_i, seq: wr_seq_i};

    generate
        for (genvar g = 0; g < CH_N; g++) begin : g_ch
            st_t ent_q;

            // One entry: a clear beats a write to the same channel.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ent_q <= '0;
                end else if (clr_i && (clr_ch_i == CH_W'(g))) begin
                    ent_q <= '0;
                end else if (wr_en_i && (wr_ch_i == CH_W'(g))) begin
                    ent_q <= w_wr;
                end
            end

            assign w_ent[g] = ent_q;
        end
    endgenerate

    // Read mux; an out-of-range channel reads as an idle entry.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < CH_N; i++) begin
            if (rd_ch_i == CH_W'(i)) begin
                w_rd = w_ent[i];
            end
        end
    end

    assign rd_init_o = w_rd.init;
    assign rd_eos_o  = w_rd.eos;
    assign rd_sid_o  = w_rd.sid;
    assign rd_seq_o  = w_rd.seq;

endmodule
`default_nettype wire

// File: rtl/miss_msg_det_mc.sv
`default_nettype none
// ============================================================================
// Module      : miss_msg_det_mc
// Description : Multi-channel MoldUDP64 missed-message detector. Tracks the
//               expected session and sequence number per feed and reports
//               sequence gaps, session gaps, stale headers and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module miss_msg_det_mc
    import moldudp64_pkg::*;
#(
    parameter int          CH_N        = 2,
    parameter int          CH_W        = ch_width(CH_N),
    parameter int          SEQ_NUM_W   = SEQ_NUM_W_DEF,
    parameter int          SID_W       = SID_W_DEF,
    parameter int          ML_W        = ML_W_DEF,
    parameter int unsigned SEQ_START   = SEQ_START_DEF,
    parameter int unsigned SID_GAP_MAX = SID_GAP_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 v_i,
    input  logic [CH_W-1:0]      ch_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,
    input  logic                 clr_i,
    input  logic [CH_W-1:0]      clr_ch_i,
    output logic                 miss_seq_num_v_o,
    output logic [CH_W-1:0]      miss_seq_num_ch_o,
    output logic [SID_W-1:0]     miss_seq_num_sid_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
    output logic                 miss_sid_v_o,
    output logic [CH_W-1:0]      miss_sid_ch_o,
    output logic [SID_W-1:0]     miss_sid_start_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
    output logic [SID_W-1:0]     miss_sid_cnt_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o,
    output logic                 drop_v_o,
    output logic                 err_v_o
);

    typedef struct packed {
        logic                 sv;
        logic [CH_W-1:0]      sch;
        logic [SID_W-1:0]     ssid;
        logic [SEQ_NUM_W-1:0] sstart;
        logic [SEQ_NUM_W-1:0] scnt;
        logic                 dv;
        logic [CH_W-1:0]      dch;
        logic [SID_W-1:0]     dstart;
        logic [SEQ_NUM_W-1:0] dsstart;
        logic [SID_W-1:0]     dcnt;
        logic [SEQ_NUM_W-1:0] dend;
        logic                 drop;
        logic                 err;
    } out_t;

    out_t out_d;
    out_t out_q;

    // Tracked state of the addressed channel and its next value.
    logic                 w_rd_init;
    logic                 w_rd_eos;
    logic [SID_W-1:0]     w_rd_sid;
    logic [SEQ_NUM_W-1:0] w_rd_seq;
    logic                 w_wr_en;
    logic                 w_wr_init;
    logic                 w_wr_eos;
    logic [SID_W-1:0]     w_wr_sid;
    logic [SEQ_NUM_W-1:0] w_wr_seq;

    // Shared compare/subtract datapath.
    logic                 w_take;
    logic                 w_ch_ok;
    logic [SEQ_NUM_W:0]   w_exp_end;
    logic                 w_carry;
    logic [SEQ_NUM_W-1:0] w_end;
    logic [SID_W-1:0]     w_sid_diff;
    logic                 w_sid_fwd;
    logic                 w_seq_roll;

    miss_msg_det_state #(
        .CH_N      (CH_N),
        .CH_W      (CH_W),
        .SID_W     (SID_W),
        .SEQ_NUM_W (SEQ_NUM_W)
    ) u_state (
        .clk       (clk),
        .reset     (reset),
        .rd_ch_i   (ch_i),
        .rd_init_o (w_rd_init),
        .rd_eos_o  (w_rd_eos),
        .rd_sid_o  (w_rd_sid),
        .rd_seq_o  (w_rd_seq),
        .wr_en_i   (w_wr_en),
        .wr_ch_i   (ch_i),
        .wr_init_i (w_wr_init),
        .wr_eos_i  (w_wr_eos),
        .wr_sid_i  (w_wr_sid),
        .wr_seq_i  (w_wr_seq),
        .clr_i     (clr_i),
        .clr_ch_i  (clr_ch_i)
    );

    // A clear aimed at the header's own channel swallows the header.
    assign w_take     = v_i && !(clr_i && (clr_ch_i == ch_i));
    assign w_ch_ok    = {1'b0, ch_i} < (CH_W+1)'(CH_N);
    assign w_exp_end  = {1'b0, seq_num_i} + (SEQ_NUM_W+1)'(msg_cnt_i);
    assign w_carry    = w_exp_end[SEQ_NUM_W];
    assign w_end      = w_exp_end[SEQ_NUM_W-1:0];
    assign w_sid_diff = sid_i - w_rd_sid;
    assign w_sid_fwd  = (sid_i > w_rd_sid) && (w_sid_diff <= SID_W'(SID_GAP_MAX));
    // Clean hand-over: next session, previous one closed, numbering restarts.
    assign w_seq_roll = (w_sid_diff == SID_W'(1)) && w_rd_eos
                        && (seq_num_i == SEQ_NUM_W'(SEQ_START));

    // Classify the header against the channel state; decide reports and update.
    always_comb begin
        out_d     = '0;
        w_wr_en   = 1'b0;
        w_wr_init = w_rd_init;
        w_wr_eos  = w_rd_eos;
        w_wr_sid  = w_rd_sid;
        w_wr_seq  = w_rd_seq;
        if (w_take) begin
            if (!w_ch_ok) begin
                out_d.drop = 1'b1;
            end else if (w_carry) begin
                out_d.err = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_init = 1'b0;
                w_wr_eos  = 1'b0;
            end else if (!w_rd_init) begin
                w_wr_en   = 1'b1;
                w_wr_init = 1'b1;
                w_wr_eos  = eos_i;
                w_wr_sid  = sid_i;
                w_wr_seq  = w_end;
            end else if (sid_i == w_rd_sid) begin
                w_wr_en  = 1'b1;
                w_wr_eos = w_rd_eos | eos_i;
                if (seq_num_i > w_rd_seq) begin
                    out_d.sv     = 1'b1;
                    out_d.sch    = ch_i;
                    out_d.ssid   = w_rd_sid;
                    out_d.sstart = w_rd_seq;
                    out_d.scnt   = seq_num_i - w_rd_seq;
                    w_wr_seq     = w_end;
                end else if (seq_num_i == w_rd_seq) begin
                    w_wr_seq = w_end;
                end else if (w_end <= w_rd_seq) begin
                    // Entirely already seen: keep the expectation, flag stale.
                    out_d.drop = 1'b1;
                end else begin
                    w_wr_seq = w_end;
                end
            end else if (w_sid_fwd) begin
                w_wr_en  = 1'b1;
                w_wr_eos = eos_i;
                w_wr_sid = sid_i;
                w_wr_seq = w_end;
                if (!w_seq_roll) begin
                    out_d.dv      = 1'b1;
                    out_d.dch     = ch_i;
                    out_d.dstart  = w_rd_sid;
                    out_d.dsstart = w_rd_seq;
                    out_d.dcnt    = w_sid_diff;
                    out_d.dend    = seq_num_i;
                end
            end else begin
                out_d.drop = 1'b1;
            end
        end
    end

    // Output registers: every report is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign miss_seq_num_v_o         = out_q.sv;
    assign miss_seq_num_ch_o        = out_q.sch;
    assign miss_seq_num_sid_o       = out_q.ssid;
    assign miss_seq_num_start_o     = out_q.sstart;
    assign miss_seq_num_cnt_o       = out_q.scnt;
    assign miss_sid_v_o             = out_q.dv;
    assign miss_sid_ch_o            = out_q.dch;
    assign miss_sid_start_o         = out_q.dstart;
    assign miss_sid_seq_num_start_o = out_q.dsstart;
    assign miss_sid_cnt_o           = out_q.dcnt;
    assign miss_sid_seq_num_end_o   = out_q.dend;
    assign drop_v_o                 = out_q.drop;
    assign err_v_o                  = out_q.err;

endmodule
`default_nettype wire

// File: tb/tb_miss_msg_det_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_miss_msg_det_mc
// Description : Self-checking bench for miss_msg_det_mc: directed vector
//               table, reset/clear corner sequences and randomized traffic
//               checked against a behavioural per-channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miss_msg_det_mc;
    import moldudp64_pkg::*;

    localparam logic [64:0] SEQ_MAX = 65'h0_FFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic        sv;
        logic        sch;
        logic [79:0] ssid;
        logic [63:0] sstart;
        logic [63:0] scnt;
        logic        dv;
        logic        dch;
        logic [79:0] dstart;
        logic [63:0] dsstart;
        logic [79:0] dcnt;
        logic [63:0] dend;
        logic        drop;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic        ch;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        eos;
        logic        clr;
        logic        clr_ch;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i;
    logic        ch_i;
    logic [79:0] sid_i;
    logic [63:0] seq_num_i;
    logic [15:0] msg_cnt_i;
    logic        eos_i;
    logic        clr_i;
    logic        clr_ch_i;
    logic        miss_seq_num_v_o;
    logic        miss_seq_num_ch_o;
    logic [79:0] miss_seq_num_sid_o;
    logic [63:0] miss_seq_num_start_o;
    logic [63:0] miss_seq_num_cnt_o;
    logic        miss_sid_v_o;
    logic        miss_sid_ch_o;
    logic [79:0] miss_sid_start_o;
    logic [63:0] miss_sid_seq_num_start_o;
    logic [79:0] miss_sid_cnt_o;
    logic [63:0] miss_sid_seq_num_end_o;
    logic        drop_v_o;
    logic        err_v_o;

    int total = 0;
    int bad   = 0;

    ch_state_t mdl [2];
    vec_t      tbl [$];

    always #5 clk = ~clk;

    miss_msg_det_mc #(.CH_N(2)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .v_i                      (v_i),
        .ch_i                     (ch_i),
        .sid_i                    (sid_i),
        .seq_num_i                (seq_num_i),
        .msg_cnt_i                (msg_cnt_i),
        .eos_i                    (eos_i),
        .clr_i                    (clr_i),
        .clr_ch_i                 (clr_ch_i),
        .miss_seq_num_v_o         (miss_seq_num_v_o),
        .miss_seq_num_ch_o        (miss_seq_num_ch_o),
        .miss_seq_num_sid_o       (miss_seq_num_sid_o),
        .miss_seq_num_start_o     (miss_seq_num_start_o),
        .miss_seq_num_cnt_o       (miss_seq_num_cnt_o),
        .miss_sid_v_o             (miss_sid_v_o),
        .miss_sid_ch_o            (miss_sid_ch_o),
        .miss_sid_start_o         (miss_sid_start_o),
        .miss_sid_seq_num_start_o (miss_sid_seq_num_start_o),
        .miss_sid_cnt_o           (miss_sid_cnt_o),
        .miss_sid_seq_num_end_o   (miss_sid_seq_num_end_o),
        .drop_v_o                 (drop_v_o),
        .err_v_o                  (err_v_o)
    );

    // ---------------- expectation builders ----------------
    function automatic exp_t e_none();
        return '0;
    endfunction

    function automatic exp_t e_seq(input logic ch, input logic [79:0] sid,
                                   input logic [63:0] st, input logic [63:0] c);
        exp_t e = '0;
        e.sv = 1'b1; e.sch = ch; e.ssid = sid; e.sstart = st; e.scnt = c;
        return e;
    endfunction

    function automatic exp_t e_sid(input logic ch, input logic [79:0] st,
                                   input logic [63:0] sst, input logic [79:0] c,
                                   input logic [63:0] en);
        exp_t e = '0;
        e.dv = 1'b1; e.dch = ch; e.dstart = st; e.dsstart = sst; e.dcnt = c; e.dend = en;
        return e;
    endfunction

    function automatic exp_t e_drop();
        exp_t e = '0;
        e.drop = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_err();
        exp_t e = '0;
        e.err = 1'b1;
        return e;
    endfunction

    function automatic vec_t row(input logic v, input logic ch, input logic [79:0] sid,
                                 input logic [63:0] seq, input logic [15:0] cnt,
                                 input logic eos, input logic clr, input logic clr_ch,
                                 input exp_t e);
        vec_t r;
        r.v = v; r.ch = ch; r.sid = sid; r.seq = seq; r.cnt = cnt;
        r.eos = eos; r.clr = clr; r.clr_ch = clr_ch; r.e = e;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Each feed: does it have a session, what session, what sequence comes next.
    task automatic model_step(input vec_t r, output exp_t e);
        logic [64:0] fin;
        logic [79:0] jump;
        e = '0;
        if (r.v && !(r.clr && (r.clr_ch == r.ch))) begin
            fin = {1'b0, r.seq} + {49'd0, r.cnt};
            if (fin > SEQ_MAX) begin
                e.err = 1'b1;
                mdl[r.ch].init = 1'b0;
            end else if (!mdl[r.ch].init) begin
                mdl[r.ch].init = 1'b1;
                mdl[r.ch].eos  = r.eos;
                mdl[r.ch].sid  = r.sid;
                mdl[r.ch].seq  = fin[63:0];
            end else if (r.sid == mdl[r.ch].sid) begin
                if (r.seq > mdl[r.ch].seq) begin
                    e = e_seq(r.ch, r.sid, mdl[r.ch].seq, r.seq - mdl[r.ch].seq);
                    mdl[r.ch].seq = fin[63:0];
                end else if ({1'b0, mdl[r.ch].seq} >= fin) begin
                    e.drop = (r.seq != mdl[r.ch].seq);
                end else begin
                    mdl[r.ch].seq = fin[63:0];
                end
                mdl[r.ch].eos = mdl[r.ch].eos | r.eos;
            end else begin
                jump = r.sid - mdl[r.ch].sid;
                if ((r.sid > mdl[r.ch].sid) && (jump <= 80'd65536)) begin
                    if (!(jump == 80'd1 && mdl[r.ch].eos && r.seq == 64'd1)) begin
                        e = e_sid(r.ch, mdl[r.ch].sid, mdl[r.ch].seq, jump, r.seq);
                    end
                    mdl[r.ch].sid = r.sid;
                    mdl[r.ch].seq = fin[63:0];
                    mdl[r.ch].eos = r.eos;
                end else begin
                    e.drop = 1'b1;
                end
            end
        end
        if (r.clr) begin
            mdl[r.clr_ch] = '0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t got, input exp_t e);
        chk({tag, "/miss_seq"}, 320'({got.sv, got.sch, got.ssid, got.sstart, got.scnt}),
                                320'({e.sv, e.sch, e.ssid, e.sstart, e.scnt}));
        chk({tag, "/miss_sid"}, 320'({got.dv, got.dch, got.dstart, got.dsstart, got.dcnt, got.dend}),
                                320'({e.dv, e.dch, e.dstart, e.dsstart, e.dcnt, e.dend}));
        chk({tag, "/drop"}, 320'(got.drop), 320'(e.drop));
        chk({tag, "/err"},  320'(got.err),  320'(e.err));
    endtask

    task automatic sample(output exp_t g);
        g.sv = miss_seq_num_v_o; g.sch = miss_seq_num_ch_o; g.ssid = miss_seq_num_sid_o;
        g.sstart = miss_seq_num_start_o; g.scnt = miss_seq_num_cnt_o;
        g.dv = miss_sid_v_o; g.dch = miss_sid_ch_o; g.dstart = miss_sid_start_o;
        g.dsstart = miss_sid_seq_num_start_o; g.dcnt = miss_sid_cnt_o;
        g.dend = miss_sid_seq_num_end_o; g.drop = drop_v_o; g.err = err_v_o;
    endtask

    // One header per cycle: drive on the falling edge, sample just after the rising edge.
    task automatic run_vec(input vec_t r, output exp_t got, output exp_t me);
        @(negedge clk);
        v_i = r.v; ch_i = r.ch; sid_i = r.sid; seq_num_i = r.seq; msg_cnt_i = r.cnt;
        eos_i = r.eos; clr_i = r.clr; clr_ch_i = r.clr_ch;
        model_step(r, me);
        @(posedge clk);
        #1;
        sample(got);
        v_i = 1'b0; clr_i = 1'b0; eos_i = 1'b0;
    endtask

    initial begin
        exp_t got;
        exp_t me;

        reset = 1'b1; v_i = 1'b0; ch_i = 1'b0; sid_i = '0; seq_num_i = '0;
        msg_cnt_i = '0; eos_i = 1'b0; clr_i = 1'b0; clr_ch_i = 1'b0;
        mdl[0] = '0; mdl[1] = '0;

        // Directed vectors: in v ch sid seq cnt eos clr clr_ch -> expected outputs.
        tbl.push_back(row(1, 0, 5,  1, 3, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 5,  4, 2, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 5, 10, 1, 0, 0, 0, e_seq(0, 5, 6, 4)));
        tbl.push_back(row(1, 0, 5, 11, 0, 1, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 6,  1, 4, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 1, 0,  1, 3, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 1, 2,  7, 1, 0, 0, 0, e_sid(1, 0, 4, 2, 7)));
        tbl.push_back(row(1, 0, 4,  5, 1, 0, 0, 0, e_drop()));
        tbl.push_back(row(1, 0, 6,  1, 1, 0, 0, 0, e_drop()));
        tbl.push_back(row(1, 0, 6,  3, 4, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 6,  9, 0, 0, 0, 0, e_seq(0, 6, 7, 2)));
        tbl.push_back(row(1, 0, 6, 64'hFFFF_FFFF_FFFF_FFFE, 5, 0, 0, 0, e_err()));
        tbl.push_back(row(1, 0, 9, 100, 1, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 9, 103, 1, 0, 1, 0, e_none()));
        tbl.push_back(row(1, 0, 9, 200, 1, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 1, 2,  8, 1, 0, 1, 0, e_none()));
        tbl.push_back(row(1, 0, 70000, 1, 1, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 1, 65539, 9, 1, 0, 0, 0, e_drop()));
        tbl.push_back(row(1, 1, 65538, 9, 1, 0, 0, 0, e_sid(1, 2, 9, 65536, 9)));
        tbl.push_back(row(1, 1, 65538, 10, 0, 1, 0, 0, e_none()));
        tbl.push_back(row(1, 1, 65539, 2, 1, 0, 0, 0, e_sid(1, 65538, 10, 1, 2)));
        tbl.push_back(row(1, 0, 70000, 5, 1, 1, 0, 0, e_seq(0, 70000, 2, 3)));
        tbl.push_back(row(1, 0, 70000, 6, 0, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 70001, 1, 2, 0, 0, 0, e_none()));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, e_none()));
        tbl.push_back(row(1, 1, 5, 50, 1, 0, 0, 0, e_none()));
        tbl.push_back(row(1, 0, 70001, 64'hFFFF_FFFF_FFFF_FFFD, 2, 0, 0, 0,
                          e_seq(0, 70001, 3, 64'hFFFF_FFFF_FFFF_FFFA)));
        tbl.push_back(row(1, 0, 70001, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, e_err()));
        tbl.push_back(row(1, 0, 70001, 64'd40, 1, 0, 0, 0, e_none()));

        repeat (3) @(posedge clk);
        #1;
        sample(got);
        cmp_all("reset", got, e_none());
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], got, me);
            cmp_all($sformatf("vec%0d", i), got, tbl[i].e);
        end

        // Mid-stream reset: channels forget everything, outputs go quiet.
        @(negedge clk);
        reset = 1'b1;
        v_i = 1'b1; ch_i = 1'b1; sid_i = 80'd99; seq_num_i = 64'd3; msg_cnt_i = 16'd1;
        @(posedge clk);
        #1;
        sample(got);
        cmp_all("midrst", got, e_none());
        v_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mdl[0] = '0; mdl[1] = '0;
        run_vec(row(1, 1, 5, 500, 1, 0, 0, 0, e_none()), got, me);
        cmp_all("reinit1", got, e_none());
        run_vec(row(1, 0, 2, 900, 0, 0, 0, 0, e_none()), got, me);
        cmp_all("reinit0", got, e_none());
        run_vec(row(1, 1, 5, 503, 1, 0, 0, 0, e_seq(1, 5, 501, 2)), got, me);
        cmp_all("after_rst_gap", got, me);

        // Randomized interleaved traffic against the model.
        for (int k = 0; k < 600; k++) begin
            vec_t r;
            int   rs;
            int   rq;
            r        = '0;
            r.v      = ($urandom_range(0, 9) != 0);
            r.ch     = 1'($urandom_range(0, 1));
            r.cnt    = 16'($urandom_range(0, 4));
            r.eos    = ($urandom_range(0, 7) == 0);
            r.clr    = ($urandom_range(0, 24) == 0);
            r.clr_ch = 1'($urandom_range(0, 1));
            rs       = $urandom_range(0, 11);
            rq       = $urandom_range(0, 19);
            if (!mdl[r.ch].init) begin
                r.sid = 80'($urandom_range(0, 20));
                r.seq = 64'($urandom_range(1, 100));
            end else begin
                case (rs)
                    6:       r.sid = mdl[r.ch].sid + 80'd1;
                    7:       r.sid = mdl[r.ch].sid + 80'd2;
                    8:       r.sid = mdl[r.ch].sid - 80'd1;
                    9:       r.sid = mdl[r.ch].sid + 80'd65536 + 80'($urandom_range(0, 1));
                    default: r.sid = mdl[r.ch].sid;
                endcase
                if (rq < 9)       r.seq = mdl[r.ch].seq;
                else if (rq < 13) r.seq = mdl[r.ch].seq + 64'($urandom_range(1, 5));
                else if (rq < 17) r.seq = mdl[r.ch].seq - 64'($urandom_range(1, 4));
                else if (rq < 19) r.seq = 64'd1;
                else              r.seq = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                if (rq == 19) r.cnt = 16'($urandom_range(0, 20));
            end
            run_vec(r, got, me);
            cmp_all($sformatf("rnd%0d", k), got, me);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
